// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers for the bus-ownership controller.
package ahb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HB_SINGLE = 3'd0,
      HB_INCR   = 3'd1,
      HB_WRAP4  = 3'd2,
      HB_INCR4  = 3'd3,
      HB_WRAP8  = 3'd4,
      HB_INCR8  = 3'd5,
      HB_WRAP16 = 3'd6,
      HB_INCR16 = 3'd7
   } hburst_t;

   // ADDR: single/idle traffic, BURST: fixed length, INCR: undefined length,
   // LOCK: owner is holding HLOCK.
   typedef enum logic [1:0] {
      ST_ADDR,
      ST_BURST,
      ST_INCR,
      ST_LOCK
   } arb_state_t;

   // Number of beats in a burst; 0 marks the undefined-length INCR.
   function automatic logic [4:0] burst_beats(hburst_t burst);
      case (burst)
         HB_SINGLE:           burst_beats = 5'd1;
         HB_WRAP4,  HB_INCR4:  burst_beats = 5'd4;
         HB_WRAP8,  HB_INCR8:  burst_beats = 5'd8;
         HB_WRAP16, HB_INCR16: burst_beats = 5'd16;
         default:             burst_beats = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin request picker: the requester closest after rr_last wins.
module rr_picker #(
   parameter  int NUM_MASTERS = 2,
   localparam int MW          = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [MW-1:0]          rr_last,
   output logic [MW-1:0]          winner,
   output logic                   valid
);

   int idx;

   // Scan from the lowest priority (rr_last itself) up to rr_last+1 so the
   // closest requester after the previous winner is the final assignment.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int off = NUM_MASTERS; off >= 1; off--) begin
         idx = (int'(rr_last) + off) % NUM_MASTERS;
         if (req[idx]) begin
            winner = MW'(idx);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arb_ctrl.sv
// AHB bus-ownership controller: round-robin arbitration that holds the bus
// across fixed bursts, undefined-length INCR bursts and locked sequences,
// and tracks the data-phase owner one phase behind the address-phase owner.
module ahb_arb_ctrl
   import ahb_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   parameter  int MAX_HOLD    = 16,
   localparam int MW          = $clog2(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS_IN,
   input  logic [2:0]             HBURST_IN,
   input  logic                   HREADY_IN,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MW-1:0]          HMASTER,
   output logic [MW-1:0]          HMASTER_D,
   output logic                   HMASTLOCK
);

   localparam int CW = ($clog2(MAX_HOLD) > 4) ? $clog2(MAX_HOLD) : 4;

   arb_state_t state;
   arb_state_t nxt_state;
   arb_state_t load_state;
   logic [CW-1:0] beat_cnt;
   logic [CW-1:0] nxt_cnt;
   logic [CW-1:0] load_cnt;
   logic [MW-1:0] rr_last;
   logic [MW-1:0] pick;
   logic          pick_valid;
   logic [MW-1:0] win;
   logic          take;
   logic          ap;
   logic          own_lock;
   htrans_t       trans;
   hburst_t       burst;

   rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .req     (HBUSREQ),
      .rr_last (rr_last),
      .winner  (pick),
      .valid   (pick_valid)
   );

   // Decide whether this cycle is an arbitration point, where the sequence
   // goes next, and who would own the bus if it is. A NONSEQ that opens a
   // multi-beat burst claims the bus, so it is not an arbitration point even
   // in ADDR; everything here only takes effect on HREADY_IN=1 edges.
   always_comb begin
      trans      = htrans_t'(HTRANS_IN);
      burst      = hburst_t'(HBURST_IN);
      own_lock   = HLOCK[HMASTER];
      load_state = ST_ADDR;
      load_cnt   = '0;
      nxt_state  = state;
      nxt_cnt    = beat_cnt;
      ap         = 1'b0;
      win        = '0;
      take       = 1'b0;

      if (own_lock) begin
         load_state = ST_LOCK;
      end else if (burst == HB_INCR) begin
         load_state = ST_INCR;
      end else if (burst != HB_SINGLE) begin
         load_state = ST_BURST;
         load_cnt   = CW'(burst_beats(burst) - 5'd1);
      end

      case (state)
         ST_ADDR: begin
            ap = 1'b1;
            if (trans == HT_NONSEQ) begin
               nxt_state = load_state;
               nxt_cnt   = load_cnt;
               if (load_state == ST_BURST || load_state == ST_INCR) ap = 1'b0;
            end
         end
         ST_BURST: begin
            case (trans)
               HT_SEQ: begin
                  if (beat_cnt == CW'(1)) begin
                     ap        = 1'b1;
                     nxt_state = ST_ADDR;
                     nxt_cnt   = '0;
                  end else begin
                     nxt_cnt = beat_cnt - CW'(1);
                  end
               end
               HT_NONSEQ: begin
                  ap        = 1'b1;
                  nxt_state = own_lock ? ST_LOCK : ST_ADDR;
                  nxt_cnt   = '0;
               end
               HT_IDLE: begin
                  ap        = 1'b1;
                  nxt_state = ST_ADDR;
                  nxt_cnt   = '0;
               end
               default: ;
            endcase
         end
         ST_INCR: begin
            case (trans)
               HT_SEQ: begin
                  if (beat_cnt == CW'(MAX_HOLD - 2)) begin
                     ap        = 1'b1;
                     nxt_state = ST_ADDR;
                     nxt_cnt   = '0;
                  end else begin
                     nxt_cnt = beat_cnt + CW'(1);
                  end
               end
               HT_NONSEQ: begin
                  ap        = 1'b1;
                  nxt_state = own_lock ? ST_LOCK : ST_ADDR;
                  nxt_cnt   = '0;
               end
               HT_IDLE: begin
                  ap        = 1'b1;
                  nxt_state = ST_ADDR;
                  nxt_cnt   = '0;
               end
               default: ;
            endcase
         end
         ST_LOCK: begin
            if (!own_lock) begin
               ap        = 1'b1;
               nxt_state = ST_ADDR;
               nxt_cnt   = '0;
            end
         end
         default: begin
            nxt_state = ST_ADDR;
            nxt_cnt   = '0;
         end
      endcase

      if (own_lock) begin
         win = HMASTER;
      end else if (pick_valid) begin
         win  = pick;
         take = 1'b1;
      end
   end

   // Sequence state, beat counter and the registered ownership outputs; a
   // low HREADY_IN freezes all of it.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= ST_ADDR;
         beat_cnt  <= '0;
         rr_last   <= MW'(NUM_MASTERS - 1);
         HGRANT    <= NUM_MASTERS'(1);
         HMASTER   <= '0;
         HMASTER_D <= '0;
         HMASTLOCK <= 1'b0;
      end else if (HREADY_IN) begin
         state     <= nxt_state;
         beat_cnt  <= nxt_cnt;
         HMASTER_D <= HMASTER;
         if (ap) begin
            HMASTER   <= win;
            HGRANT    <= NUM_MASTERS'(1) << win;
            HMASTLOCK <= HLOCK[win];
            if (take) rr_last <= win;
         end else begin
            HMASTLOCK <= own_lock;
         end
      end
   end

endmodule

// File: tb/tb_ahb_arb_ctrl.sv
// Scoreboard bench for ahb_arb_ctrl: a behavioural ownership model predicts
// the outputs after every clock edge, a monitor compares them at negedge.
module tb_ahb_arb_ctrl;

   localparam int N    = 2;
   localparam int MAXH = 16;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;
   localparam logic [2:0] B_SINGLE = 3'd0;
   localparam logic [2:0] B_INCR   = 3'd1;
   localparam logic [2:0] B_INCR4  = 3'd3;
   localparam logic [2:0] B_INCR8  = 3'd5;
   localparam logic [2:0] B_INCR16 = 3'd7;

   localparam int MODE_FREE   = 0;
   localparam int MODE_FIXED  = 1;
   localparam int MODE_UNDEF  = 2;
   localparam int MODE_LOCKED = 3;

   logic         HCLK      = 1'b0;
   logic         HRESET    = 1'b0;
   logic [N-1:0] HBUSREQ   = '0;
   logic [N-1:0] HLOCK     = '0;
   logic [1:0]   HTRANS_IN = '0;
   logic [2:0]   HBURST_IN = '0;
   logic         HREADY_IN = 1'b1;
   logic [N-1:0] HGRANT;
   logic [0:0]   HMASTER;
   logic [0:0]   HMASTER_D;
   logic         HMASTLOCK;

   typedef struct packed {
      logic [N-1:0] grant;
      logic [0:0]   master;
      logic [0:0]   master_d;
      logic         mlock;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   int   m_owner, m_downer, m_last, m_mode, m_left, m_seen;
   logic m_lock;

   ahb_arb_ctrl #(.NUM_MASTERS(N), .MAX_HOLD(MAXH)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HBUSREQ   (HBUSREQ),
      .HLOCK     (HLOCK),
      .HTRANS_IN (HTRANS_IN),
      .HBURST_IN (HBURST_IN),
      .HREADY_IN (HREADY_IN),
      .HGRANT    (HGRANT),
      .HMASTER   (HMASTER),
      .HMASTER_D (HMASTER_D),
      .HMASTLOCK (HMASTLOCK)
   );

   // 10-time-unit bus clock
   always #5 HCLK = ~HCLK;

   function automatic int burstLen(logic [2:0] b);
      case (b)
         3'd2, 3'd3: burstLen = 4;
         3'd4, 3'd5: burstLen = 8;
         3'd6, 3'd7: burstLen = 16;
         default:    burstLen = 1;
      endcase
   endfunction

   function automatic exp_t modelExpect();
      exp_t e;
      e.grant    = N'(1) << m_owner;
      e.master   = 1'(m_owner);
      e.master_d = 1'(m_downer);
      e.mlock    = m_lock;
      return e;
   endfunction

   task automatic modelReset();
      m_owner  = 0;
      m_downer = 0;
      m_last   = N - 1;
      m_mode   = MODE_FREE;
      m_left   = 0;
      m_seen   = 0;
      m_lock   = 1'b0;
   endtask

   // Ownership rules: beats remaining for fixed bursts, beats seen for INCR,
   // lock holds the owner; at a handover the next requester after the last
   // winner takes the bus, otherwise master 0 is parked.
   task automatic modelStep(input logic [N-1:0] req, input logic [N-1:0] lock,
                            input logic [1:0] trans, input logic [2:0] burst,
                            input logic ready);
      logic own_lock;
      bit   ap;
      int   w;
      if (!ready) return;
      own_lock = lock[m_owner];
      ap = 0;
      case (m_mode)
         MODE_FREE: begin
            if (trans == T_NONSEQ && own_lock) begin
               m_mode = MODE_LOCKED; ap = 1;
            end else if (trans == T_NONSEQ && burst == B_INCR) begin
               m_mode = MODE_UNDEF; m_seen = 1;
            end else if (trans == T_NONSEQ && burst != B_SINGLE) begin
               m_mode = MODE_FIXED; m_left = burstLen(burst) - 1;
            end else begin
               ap = 1;
            end
         end
         MODE_FIXED: begin
            if (trans == T_SEQ) begin
               m_left--;
               if (m_left == 0) begin ap = 1; m_mode = MODE_FREE; end
            end else if (trans == T_IDLE) begin
               ap = 1; m_mode = MODE_FREE;
            end else if (trans == T_NONSEQ) begin
               ap = 1; m_mode = own_lock ? MODE_LOCKED : MODE_FREE;
            end
         end
         MODE_UNDEF: begin
            if (trans == T_SEQ) begin
               m_seen++;
               if (m_seen == MAXH) begin ap = 1; m_mode = MODE_FREE; end
            end else if (trans == T_IDLE) begin
               ap = 1; m_mode = MODE_FREE;
            end else if (trans == T_NONSEQ) begin
               ap = 1; m_mode = own_lock ? MODE_LOCKED : MODE_FREE;
            end
         end
         default: begin
            if (!own_lock) begin ap = 1; m_mode = MODE_FREE; end
         end
      endcase
      m_downer = m_owner;
      if (ap) begin
         if (!own_lock) begin
            w = -1;
            for (int k = 1; k <= N; k++)
               if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
            if (w >= 0) begin
               m_owner = w;
               m_last  = w;
            end else begin
               m_owner = 0;
            end
         end
         m_lock = lock[m_owner];
      end else begin
         m_lock = own_lock;
      end
   endtask

   task automatic checkOutput(input string tag, input exp_t e);
      checks++;
      if (HGRANT !== e.grant) begin
         errors++;
         $display("[TB] FAIL %s HGRANT: got %b expected %b at %0t", tag, HGRANT, e.grant, $time);
      end
      checks++;
      if (HMASTER !== e.master) begin
         errors++;
         $display("[TB] FAIL %s HMASTER: got %0d expected %0d at %0t", tag, HMASTER, e.master, $time);
      end
      checks++;
      if (HMASTER_D !== e.master_d) begin
         errors++;
         $display("[TB] FAIL %s HMASTER_D: got %0d expected %0d at %0t", tag, HMASTER_D, e.master_d, $time);
      end
      checks++;
      if (HMASTLOCK !== e.mlock) begin
         errors++;
         $display("[TB] FAIL %s HMASTLOCK: got %b expected %b at %0t", tag, HMASTLOCK, e.mlock, $time);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then queue the prediction.
   task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] lock,
                                input logic [1:0] trans, input logic [2:0] burst,
                                input logic ready);
      HBUSREQ   = req;
      HLOCK     = lock;
      HTRANS_IN = trans;
      HBURST_IN = burst;
      HREADY_IN = ready;
      @(posedge HCLK);
      modelStep(req, lock, trans, burst, ready);
      exp_q.push_back(modelExpect());
      #2;
   endtask

   task automatic doReset(input int cycles);
      HRESET = 1'b1;
      #1;
      modelReset();
      exp_q.delete();
      checkOutput("reset_now", modelExpect());
      repeat (cycles) begin
         @(posedge HCLK);
         exp_q.push_back(modelExpect());
      end
      #2;
      HRESET = 1'b0;
   endtask

   task automatic getOwner(input int target);
      for (int i = 0; i < 8 && m_owner != target; i++)
         applyStimulus(N'(1) << target, '0, T_IDLE, B_SINGLE, 1'b1);
      if (m_owner != target) begin
         errors++;
         $display("[TB] FAIL get_owner: owner %0d expected %0d", m_owner, target);
      end
   endtask

   // Monitor: compare the DUT against the oldest queued prediction each negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge HCLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("mon", e);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      #1;
      $display("[TB] reset and idle park");
      doReset(2);
      repeat (10) applyStimulus(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1);

      $display("[TB] alternating single transfers");
      repeat (6) applyStimulus(2'b11, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);

      $display("[TB] M1 INCR4 with M0 requesting");
      getOwner(1);
      applyStimulus(2'b11, 2'b00, T_NONSEQ, B_INCR4, 1'b1);
      repeat (3) applyStimulus(2'b11, 2'b00, T_SEQ, B_INCR4, 1'b1);
      repeat (3) applyStimulus(2'b11, 2'b00, T_IDLE, B_SINGLE, 1'b1);

      $display("[TB] INCR8 with wait states on beat 2");
      getOwner(1);
      applyStimulus(2'b11, 2'b00, T_NONSEQ, B_INCR8, 1'b1);
      repeat (3) applyStimulus(2'b11, 2'b00, T_SEQ, B_INCR8, 1'b0);
      repeat (7) applyStimulus(2'b11, 2'b00, T_SEQ, B_INCR8, 1'b1);
      repeat (3) applyStimulus(2'b11, 2'b00, T_IDLE, B_SINGLE, 1'b1);

      $display("[TB] undefined INCR forced handover");
      getOwner(0);
      applyStimulus(2'b11, 2'b00, T_NONSEQ, B_INCR, 1'b1);
      for (int i = 0; i < 30 && m_owner == 0; i++)
         applyStimulus(2'b11, 2'b00, T_SEQ, B_INCR, 1'b1);
      repeat (3) applyStimulus(2'b11, 2'b00, T_IDLE, B_SINGLE, 1'b1);

      $display("[TB] locked sequence");
      getOwner(0);
      repeat (2) applyStimulus(2'b11, 2'b01, T_NONSEQ, B_SINGLE, 1'b1);
      repeat (3) applyStimulus(2'b11, 2'b01, T_IDLE, B_SINGLE, 1'b1);
      repeat (3) applyStimulus(2'b11, 2'b00, T_IDLE, B_SINGLE, 1'b1);

      $display("[TB] reset in the middle of a burst");
      getOwner(1);
      applyStimulus(2'b11, 2'b00, T_NONSEQ, B_INCR16, 1'b1);
      repeat (3) applyStimulus(2'b11, 2'b00, T_SEQ, B_INCR16, 1'b1);
      doReset(2);
      repeat (3) applyStimulus(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1);

      $display("[TB] randomized traffic");
      repeat (500) begin
         logic [N-1:0] rq, lk;
         logic [1:0]   tr;
         logic [2:0]   bu;
         logic         rd;
         rq = N'($urandom_range(0, 3));
         lk = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 3)) : '0;
         tr = 2'($urandom_range(0, 3));
         bu = 3'($urandom_range(0, 7));
         rd = ($urandom_range(0, 3) != 0);
         applyStimulus(rq, lk, tr, bu, rd);
      end

      repeat (3) @(negedge HCLK);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
